// File: rtl/pr_decouple_ctrl.sv
// -----------------------------------------------------------------------------
// pr_decouple_ctrl
//
// Sequences the PR decoupler that sits on the PCIe/XDMA boundary between the
// static shell and the reconfigurable partition (RP).
//
//   COUPLED    -> DRAIN      decouple_req rises; the RP is asked to quiesce.
//   DRAIN      -> DECOUPLED  all four streams sit at packet boundaries and no
//                            cfg_mgmt access is outstanding, or the drain
//                            timeout expires (timeout_err is then set).
//   DRAIN      -> COUPLED    decouple_req withdrawn before the drain finished.
//   DECOUPLED  -> RECOUPLE   decouple_req falls; the RP is released from reset.
//   RECOUPLE   -> COUPLED    RECOUPLE_DELAY cycles after rp_resetn rose.
//   RECOUPLE   -> DECOUPLED  decouple_req raised again while settling.
//
// Handshake semantics: a stream beat is transferred in a cycle where both
// tvalid and tready are 1 at the rising edge of axi_aclk; tvalid alone
// (without tready) transfers nothing but still marks the stream as active.
//
// Ports:
//   axi_aclk, axi_aresetn        clock, asynchronous active-low reset
//   decouple_req                 level request, 1 = decouple
//   {cq,rc,cc,rq}_t{valid,ready,last}  stream monitors
//   cfg_mgmt_read_en/_write_en   cfg_mgmt request strobes from the RP
//   cfg_mgmt_read_write_done     cfg_mgmt completion
//   pr_decouple                  to the decoupler's PR_DECOUPLE input
//   rp_quiesce_req               asks the RP to stop starting new work
//   rp_resetn                    active-low reset to the RP
//   decouple_status              1 while DECOUPLED
//   busy                         1 in DRAIN or RECOUPLE
//   timeout_err                  sticky drain-timeout flag
//   fsm_state                    current FSM state (debug observation)
// -----------------------------------------------------------------------------
module pr_decouple_ctrl #(
    parameter int DRAIN_TIMEOUT     = 4096,
    parameter int RECOUPLE_DELAY    = 64,
    parameter bit DECOUPLE_AT_RESET = 1'b1
) (
    input  logic       axi_aclk,
    input  logic       axi_aresetn,
    input  logic       decouple_req,
    input  logic       cq_tvalid,
    input  logic       cq_tready,
    input  logic       cq_tlast,
    input  logic       rc_tvalid,
    input  logic       rc_tready,
    input  logic       rc_tlast,
    input  logic       cc_tvalid,
    input  logic       cc_tready,
    input  logic       cc_tlast,
    input  logic       rq_tvalid,
    input  logic       rq_tready,
    input  logic       rq_tlast,
    input  logic       cfg_mgmt_read_en,
    input  logic       cfg_mgmt_write_en,
    input  logic       cfg_mgmt_read_write_done,
    output logic       pr_decouple,
    output logic       rp_quiesce_req,
    output logic       rp_resetn,
    output logic       decouple_status,
    output logic       busy,
    output logic       timeout_err,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        ST_COUPLED   = 2'd0,
        ST_DRAIN     = 2'd1,
        ST_DECOUPLED = 2'd2,
        ST_RECOUPLE  = 2'd3
    } state_t;

    localparam state_t RESET_STATE = DECOUPLE_AT_RESET ? ST_DECOUPLED : ST_COUPLED;

    // One spare bit so the counters can saturate past their terminal value.
    localparam int DW = $clog2(DRAIN_TIMEOUT) + 1;
    localparam int RW = $clog2(RECOUPLE_DELAY) + 1;
    localparam logic [DW-1:0] DRAIN_LAST    = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [RW-1:0] RECOUPLE_LAST = RW'(RECOUPLE_DELAY - 1);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] drain_cnt;
    logic [RW-1:0] recouple_cnt;
    logic          timeout_nxt;

    logic pkt_cq, pkt_rc, pkt_cc, pkt_rq;
    logic cfg_pend;
    logic idle;

    logic cq_beat, rc_beat, cc_beat, rq_beat;

    assign cq_beat = cq_tvalid & cq_tready;
    assign rc_beat = rc_tvalid & rc_tready;
    assign cc_beat = cc_tvalid & cc_tready;
    assign rq_beat = rq_tvalid & rq_tready;

    assign fsm_state = state;

    // -------------------------------------------------------------------------
    // Packet-boundary and cfg_mgmt tracking. While decoupled the RP is held in
    // reset and its streams are cut off, so any partial state is discarded.
    // -------------------------------------------------------------------------
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pkt_cq   <= 1'b0;
            pkt_rc   <= 1'b0;
            pkt_cc   <= 1'b0;
            pkt_rq   <= 1'b0;
            cfg_pend <= 1'b0;
        end else if (state == ST_DECOUPLED) begin
            pkt_cq   <= 1'b0;
            pkt_rc   <= 1'b0;
            pkt_cc   <= 1'b0;
            pkt_rq   <= 1'b0;
            cfg_pend <= 1'b0;
        end else begin
            if (cq_beat) pkt_cq <= ~cq_tlast;
            if (rc_beat) pkt_rc <= ~rc_tlast;
            if (cc_beat) pkt_cc <= ~cc_tlast;
            if (rq_beat) pkt_rq <= ~rq_tlast;
            // A new request in the same cycle as a completion keeps the
            // access pending: the new one has not finished yet.
            if (cfg_mgmt_read_en | cfg_mgmt_write_en)
                cfg_pend <= 1'b1;
            else if (cfg_mgmt_read_write_done)
                cfg_pend <= 1'b0;
        end
    end

    // Idle also requires no tvalid and no cfg strobe in the current cycle, so
    // a beat or access that is just being offered is never cut in half.
    assign idle = ~pkt_cq & ~pkt_rc & ~pkt_cc & ~pkt_rq & ~cfg_pend
                & ~cq_tvalid & ~rc_tvalid & ~cc_tvalid & ~rq_tvalid
                & ~cfg_mgmt_read_en & ~cfg_mgmt_write_en;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        timeout_nxt = timeout_err;
        case (state)
            ST_COUPLED: begin
                if (decouple_req) begin
                    state_nxt   = ST_DRAIN;
                    timeout_nxt = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (!decouple_req) begin
                    state_nxt = ST_COUPLED;
                end else if (idle) begin
                    // Idle takes priority over a coincident timeout.
                    state_nxt = ST_DECOUPLED;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt   = ST_DECOUPLED;
                    timeout_nxt = 1'b1;
                end
            end
            ST_DECOUPLED: begin
                if (!decouple_req) state_nxt = ST_RECOUPLE;
            end
            ST_RECOUPLE: begin
                if (decouple_req)
                    state_nxt = ST_DECOUPLED;
                else if (recouple_cnt == RECOUPLE_LAST)
                    state_nxt = ST_COUPLED;
            end
            default: state_nxt = RESET_STATE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters and registered outputs. Outputs are decoded from the
    // next state so they change on the same edge as the state register.
    // Counters are cleared outside their own state, which gives a zero count
    // on the first cycle of every entry.
    // -------------------------------------------------------------------------
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state           <= RESET_STATE;
            drain_cnt       <= '0;
            recouple_cnt    <= '0;
            timeout_err     <= 1'b0;
            pr_decouple     <= DECOUPLE_AT_RESET;
            rp_resetn       <= ~DECOUPLE_AT_RESET;
            decouple_status <= DECOUPLE_AT_RESET;
            rp_quiesce_req  <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= timeout_nxt;

            if (state == ST_DRAIN) begin
                if (drain_cnt != '1) drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end

            if (state == ST_RECOUPLE) begin
                if (recouple_cnt != '1) recouple_cnt <= recouple_cnt + 1'b1;
            end else begin
                recouple_cnt <= '0;
            end

            pr_decouple     <= (state_nxt == ST_DECOUPLED) || (state_nxt == ST_RECOUPLE);
            rp_resetn       <= (state_nxt != ST_DECOUPLED);
            decouple_status <= (state_nxt == ST_DECOUPLED);
            rp_quiesce_req  <= (state_nxt == ST_DRAIN);
            busy            <= (state_nxt == ST_DRAIN) || (state_nxt == ST_RECOUPLE);
        end
    end

endmodule

// File: tb/tb_pr_decouple_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for pr_decouple_ctrl (DRAIN_TIMEOUT=16, RECOUPLE_DELAY=64,
// DECOUPLE_AT_RESET=1). The stimulus pushes {cycle, output vector} for every
// output change it expects; the monitor pops one entry whenever the observed
// output vector changes and compares both the value and the cycle it changed.
// Output vector: {fsm_state[1:0], pr_decouple, rp_quiesce_req, rp_resetn,
//                 decouple_status, busy, timeout_err}
// -----------------------------------------------------------------------------
module tb_pr_decouple_ctrl;

  localparam int EW = 40;

  localparam logic [7:0] V_CPL = {2'd0, 6'b001000};
  localparam logic [7:0] V_DRN = {2'd1, 6'b011010};
  localparam logic [7:0] V_DEC = {2'd2, 6'b100100};
  localparam logic [7:0] V_REC = {2'd3, 6'b101010};
  localparam logic [7:0] V_TO  = 8'h01;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT
  logic decouple_req = 1'b0;
  logic cq_tvalid = 1'b0, cq_tready = 1'b0, cq_tlast = 1'b0;
  logic rc_tvalid = 1'b0, rc_tready = 1'b0, rc_tlast = 1'b0;
  logic cc_tvalid = 1'b0, cc_tready = 1'b0, cc_tlast = 1'b0;
  logic rq_tvalid = 1'b0, rq_tready = 1'b0, rq_tlast = 1'b0;
  logic cfg_mgmt_read_en = 1'b0, cfg_mgmt_write_en = 1'b0;
  logic cfg_mgmt_read_write_done = 1'b0;
  logic pr_decouple, rp_quiesce_req, rp_resetn, decouple_status, busy, timeout_err;
  logic [1:0] fsm_state;

  pr_decouple_ctrl #(
    .DRAIN_TIMEOUT(16),
    .RECOUPLE_DELAY(64),
    .DECOUPLE_AT_RESET(1'b1)
  ) dut (
    .axi_aclk(clk),
    .axi_aresetn(rst_n),
    .decouple_req(decouple_req),
    .cq_tvalid(cq_tvalid), .cq_tready(cq_tready), .cq_tlast(cq_tlast),
    .rc_tvalid(rc_tvalid), .rc_tready(rc_tready), .rc_tlast(rc_tlast),
    .cc_tvalid(cc_tvalid), .cc_tready(cc_tready), .cc_tlast(cc_tlast),
    .rq_tvalid(rq_tvalid), .rq_tready(rq_tready), .rq_tlast(rq_tlast),
    .cfg_mgmt_read_en(cfg_mgmt_read_en),
    .cfg_mgmt_write_en(cfg_mgmt_write_en),
    .cfg_mgmt_read_write_done(cfg_mgmt_read_write_done),
    .pr_decouple(pr_decouple),
    .rp_quiesce_req(rp_quiesce_req),
    .rp_resetn(rp_resetn),
    .decouple_status(decouple_status),
    .busy(busy),
    .timeout_err(timeout_err),
    .fsm_state(fsm_state)
  );

  logic [7:0] cur;
  assign cur = {fsm_state, pr_decouple, rp_quiesce_req, rp_resetn,
                decouple_status, busy, timeout_err};

  // ---------------------------------------------------------------- scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_at(input int c, input logic [7:0] v);
    logic [31:0] cw;
    cw = c;
    exp_q.push_back({cw, v});
  endtask

  // Monitor: every change of the output vector consumes one expected entry.
  logic [7:0] prev = 8'hxx;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [31:0] cw;
    if (cur !== prev) begin
      cw = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cycle %0d outputs %b, none expected", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e !== {cw, cur}) begin
          errors++;
          $display("FAIL output_change: got cycle %0d outputs %b, expected cycle %0d outputs %b",
                   cyc, cur, e[EW-1:8], e[7:0]);
        end
      end
      prev = cur;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drop decouple_req from DECOUPLED and expect a full recouple sequence.
  task automatic release_seq(input logic [7:0] to);
    int r;
    r = cyc;
    decouple_req = 1'b0;
    expect_at(r + 1, V_REC | to);
    expect_at(r + 65, V_CPL | to);
    step(70);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int m;
    // Reset into DECOUPLED; the first monitor sample is at cycle 1.
    #1 rst_n = 1'b0;
    expect_at(1, V_DEC);
    step(3);
    rst_n = 1'b1;
    // Release with decouple_req=0: rp_resetn rises next edge, recouple 64 later.
    release_seq(8'h00);

    // RQ mid-packet: three beats of a five-beat packet, then request decouple.
    rq_tvalid = 1'b1; rq_tready = 1'b1; rq_tlast = 1'b0;
    step(3);
    rq_tvalid = 1'b0;
    m = cyc;
    decouple_req = 1'b1;
    expect_at(m + 1, V_DRN);
    expect_at(m + 7, V_DEC);
    step(4);
    rq_tvalid = 1'b1;
    step(1);
    rq_tlast = 1'b1;
    step(1);
    rq_tvalid = 1'b0; rq_tlast = 1'b0;
    step(2);
    release_seq(8'h00);

    // Pending cfg_mgmt write, completion 10 cycles after the enable.
    m = cyc;
    cfg_mgmt_write_en = 1'b1;
    expect_at(m + 2, V_DRN);
    expect_at(m + 12, V_DEC);
    step(1);
    cfg_mgmt_write_en = 1'b0;
    decouple_req = 1'b1;
    step(9);
    cfg_mgmt_read_write_done = 1'b1;
    step(1);
    cfg_mgmt_read_write_done = 1'b0;
    step(3);
    release_seq(8'h00);

    // CC stuck mid-packet: drain times out after 16 DRAIN cycles.
    cc_tvalid = 1'b1; cc_tready = 1'b1; cc_tlast = 1'b0;
    step(1);
    cc_tready = 1'b0;
    m = cyc;
    decouple_req = 1'b1;
    expect_at(m + 1, V_DRN);
    expect_at(m + 17, V_DEC | V_TO);
    step(20);
    cc_tvalid = 1'b0;
    release_seq(V_TO);

    // Next decouple clears timeout_err on DRAIN entry; idle drain takes 1 cycle.
    m = cyc;
    decouple_req = 1'b1;
    expect_at(m + 1, V_DRN);
    expect_at(m + 2, V_DEC);
    step(3);

    // Re-raise during RECOUPLE at count 10.
    m = cyc;
    decouple_req = 1'b0;
    expect_at(m + 1, V_REC);
    expect_at(m + 12, V_DEC);
    step(11);
    decouple_req = 1'b1;
    step(3);
    release_seq(8'h00);

    // Abort during DRAIN (RQ offering a beat that is never accepted).
    m = cyc;
    rq_tvalid = 1'b1; rq_tready = 1'b0;
    decouple_req = 1'b1;
    expect_at(m + 1, V_DRN);
    expect_at(m + 4, V_CPL);
    step(3);
    decouple_req = 1'b0;
    rq_tvalid = 1'b0;
    step(4);

    // Asynchronous reset in the middle of DRAIN.
    m = cyc;
    rq_tvalid = 1'b1;
    decouple_req = 1'b1;
    expect_at(m + 1, V_DRN);
    expect_at(m + 3, V_DEC);
    step(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if (cur !== V_DEC) begin
      errors++;
      $display("FAIL async_reset: outputs %b one ns after reset, expected %b", cur, V_DEC);
    end
    decouple_req = 1'b0;
    rq_tvalid = 1'b0;
    step(2);
    rst_n = 1'b1;
    release_seq(8'h00);

    step(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL expected_drained: %0d expected changes never seen, 0 required", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the whole run is well under 1000 cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, finish required earlier", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pr_decouple_ctrl.md
Name: pr_decouple_ctrl

Overview:
Sequences the PR decoupler around the PCIe/XDMA boundary between the static shell and the reconfigurable partition (RP).
- On a decouple request, it asks the RP to quiesce and waits for all four AXI-stream interfaces (CQ, RC, CC, RQ) to reach packet boundaries and for any cfg_mgmt access to complete.
- It then asserts pr_decouple and holds the RP in reset.
- On release, it de-asserts the RP reset, waits a settling delay, then recouples.
- A drain timeout forces decoupling if the RP never goes idle.

Parameters:
DRAIN_TIMEOUT, 4096, max cycles spent in DRAIN before forced decouple (>=2).
RECOUPLE_DELAY, 64, cycles from rp_resetn release to pr_decouple de-assertion (>=1).
DECOUPLE_AT_RESET, 1, 1: reset into DECOUPLED; 0: reset into COUPLED.

Ports:
axi_aclk  in  1  clock (XDMA user clock)
axi_aresetn  in  1  asynchronous active-low reset
decouple_req  in  1  level request from the shell management register; 1 = decouple
cq_tvalid / cq_tready / cq_tlast  in  1 each  CQ stream monitor (shell to RP side)
rc_tvalid / rc_tready / rc_tlast  in  1 each  RC stream monitor
cc_tvalid / cc_tready / cc_tlast  in  1 each  CC stream monitor (RP to shell side)
rq_tvalid / rq_tready / rq_tlast  in  1 each  RQ stream monitor (rq_tready = s_axis_rq_tready[0])
cfg_mgmt_read_en / cfg_mgmt_write_en  in  1 each  RP cfg_mgmt request strobes
cfg_mgmt_read_write_done  in  1  cfg_mgmt completion
pr_decouple  out  1  drives the PR_DECOUPLE input of the decoupler
rp_quiesce_req  out  1  asks the RP to stop starting new packets and cfg accesses
rp_resetn  out  1  active-low reset to the RP
decouple_status  out  1  1 while in DECOUPLED
busy  out  1  1 in DRAIN or RECOUPLE
timeout_err  out  1  sticky; set on drain timeout, cleared on a new entry to DRAIN

Behaviour:
- All outputs are registered. Async reset clears all internal counters and flags.
- Reset values:
  - DECOUPLE_AT_RESET=1: state DECOUPLED, pr_decouple=1, rp_resetn=0, decouple_status=1.
  - DECOUPLE_AT_RESET=0: state COUPLED, pr_decouple=0, rp_resetn=1, decouple_status=0.
  - Either case: rp_quiesce_req=0, busy=0, timeout_err=0.
- Per-stream in-packet flag pkt_x:
  - On a beat (tvalid&tready) with tlast=0: set to 1.
  - On a beat with tlast=1: clear to 0. A single-beat packet leaves the flag 0.
  - With no beat, the flag holds.
- cfg_pend flag:
  - Set on read_en|write_en; cleared on read_write_done.
  - If done and a new enable occur in the same cycle, cfg_pend=1.
- idle = ~pkt_cq & ~pkt_rc & ~pkt_cc & ~pkt_rq & ~cfg_pend & ~any tvalid (all four) & ~read_en & ~write_en, evaluated combinationally from the current-cycle flags.
- States:
  - COUPLED:
    - Outputs: pr_decouple=0, rp_resetn=1.
    - If decouple_req=1, go to DRAIN next cycle. Entering DRAIN: rp_quiesce_req=1, drain counter=0, timeout_err=0.
  - DRAIN:
    - Counter increments every cycle.
    - decouple_req=0 → abort: return to COUPLED, rp_quiesce_req=0, no decouple.
    - Else if idle=1 → DECOUPLED next cycle: pr_decouple=1, rp_resetn=0, rp_quiesce_req=0.
    - Else if counter==DRAIN_TIMEOUT-1 → DECOUPLED, timeout_err=1.
    - Idle and timeout in the same cycle → DECOUPLED with timeout_err=0 (idle wins).
    - Minimum latency from decouple_req rising to pr_decouple=1: 2 cycles.
  - DECOUPLED:
    - Outputs: pr_decouple=1, rp_resetn=0. pkt_* and cfg_pend are forced to 0 (decoupled streams are ignored).
    - If decouple_req=0, go to RECOUPLE: rp_resetn=1, delay counter=0.
  - RECOUPLE:
    - Counter increments every cycle; pr_decouple stays 1.
    - decouple_req=1 → return to DECOUPLED immediately, rp_resetn=0.
    - Else at counter==RECOUPLE_DELAY-1 → COUPLED: pr_decouple=0.
    - rp_resetn rise to pr_decouple fall is exactly RECOUPLE_DELAY cycles.
- Counters saturate; they never wrap.
- A mid-operation reset immediately returns to the reset state; no partial sequence resumes.

Test Plan:
- DECOUPLE_AT_RESET=1, release reset, decouple_req=0 → rp_resetn rises on cycle 1; pr_decouple falls exactly 64 cycles later; busy=1 in between.
- From COUPLED, raise decouple_req with RQ mid-packet (3 beats of a 5-beat packet sent) → rp_quiesce_req=1, pr_decouple stays 0 until the beat with tlast is accepted; pr_decouple=1 on the following cycle.
- Pending cfg_mgmt write (write_en pulse, done 10 cycles later) plus decouple_req → pr_decouple asserts 1 cycle after done; timeout_err=0.
- DRAIN_TIMEOUT=16, CC stuck mid-packet (tready=0) → pr_decouple=1 and timeout_err=1 after 16 DRAIN cycles; next decouple cycle clears timeout_err on DRAIN entry.
- decouple_req dropped during DRAIN → back to COUPLED next cycle, pr_decouple never asserts. Re-raised during RECOUPLE at count 10 → DECOUPLED next cycle, rp_resetn=0.
- Assert axi_aresetn low mid-DRAIN → outputs take reset values asynchronously, without waiting for a clock edge.
